// File: rtl/cp0_interrupt_unit_if.sv
// Bus between the decoder/datapath and the CP0 interrupt unit.
//   master : CPU side, drives decoded strobes, operands, next-PC and the raw irq lines
//   slave  : CP0 side, returns mfc0 data, PC redirect request/address and handler flag
interface cp0_interrupt_unit_if;
  logic        instr_valid;
  logic        mtc0;
  logic        mfc0;
  logic        eret;
  logic [4:0]  reg_number;
  logic [31:0] write_data;
  logic [31:0] pc_next;
  logic [2:0]  irq_request;
  logic [31:0] read_data;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        in_handler;

  modport master (
    output instr_valid, mtc0, mfc0, eret, reg_number, write_data, pc_next, irq_request,
    input  read_data, redirect, redirect_addr, in_handler
  );

  modport slave (
    input  instr_valid, mtc0, mfc0, eret, reg_number, write_data, pc_next, irq_request,
    output read_data, redirect, redirect_addr, in_handler
  );
endinterface

// File: rtl/cp0_interrupt_unit.sv
// CP0 Status/Cause/EPC and interrupt sequencer for a single-cycle MIPS datapath.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rstn_i : synchronous active-low reset
//   bus    : slave modport of cp0_interrupt_unit_if (strobes, operands, irq lines in;
//            read_data, redirect, redirect_addr, in_handler out)
// Status (12): [0] IE, [3:1] per-source mask. Cause (13): [2:0] pending, [5:4] last source.
// EPC (14): return address. Source 2 has highest priority.
module cp0_interrupt_unit #(
  parameter logic [31:0] Handler0    = 32'h0000_1000,
  parameter logic [31:0] Handler1    = 32'h0000_1100,
  parameter logic [31:0] Handler2    = 32'h0000_1200,
  parameter logic [3:0]  ResetStatus = 4'b1111
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  cp0_interrupt_unit_if.slave bus
);

  logic [2:0]  sync1_q, sync2_q, prev_q;
  logic [2:0]  pending_q, pending_d;
  logic [3:0]  status_q, status_d;
  logic [1:0]  cause_src_q, cause_src_d;
  logic [31:0] epc_q, epc_d;
  logic        in_handler_q, in_handler_d;

  logic [2:0]  rise, eligible, taken_mask, clear_mask;
  logic [1:0]  sel;
  logic [31:0] vector;
  logic        take, do_eret, wr_status, wr_cause, wr_epc;

  always_comb begin
    rise     = sync2_q & ~prev_q;
    eligible = pending_q & status_q[3:1];
    do_eret  = bus.instr_valid & bus.eret;
    take     = bus.instr_valid & status_q[0] & (|eligible) & ~bus.mtc0 & ~bus.eret;

    if (eligible[2])      sel = 2'd2;
    else if (eligible[1]) sel = 2'd1;
    else                  sel = 2'd0;

    case (sel)
      2'd2:    vector = Handler2;
      2'd1:    vector = Handler1;
      default: vector = Handler0;
    endcase

    wr_status  = bus.instr_valid & bus.mtc0 & (bus.reg_number == 5'd12);
    wr_cause   = bus.instr_valid & bus.mtc0 & (bus.reg_number == 5'd13);
    wr_epc     = bus.instr_valid & bus.mtc0 & (bus.reg_number == 5'd14);
    taken_mask = take ? (3'b001 << sel) : 3'b000;
    clear_mask = wr_cause ? bus.write_data[2:0] : 3'b000;

    // A fresh edge overrides both the take-clear and software W1C.
    pending_d = (pending_q & ~taken_mask & ~clear_mask) | rise;

    status_d     = status_q;
    cause_src_d  = cause_src_q;
    epc_d        = epc_q;
    in_handler_d = in_handler_q;

    if (wr_status) status_d = bus.write_data[3:0];
    if (wr_epc)    epc_d    = bus.write_data;
    if (take) begin
      status_d[0]  = 1'b0;
      epc_d        = bus.pc_next;
      cause_src_d  = sel;
      in_handler_d = 1'b1;
    end
    if (do_eret) begin
      status_d[0]  = 1'b1;
      in_handler_d = 1'b0;
    end
  end

  always_comb begin
    bus.redirect      = take | do_eret;
    bus.redirect_addr = do_eret ? epc_q : vector;
    bus.in_handler    = in_handler_q;
    case (bus.reg_number)
      5'd12:   bus.read_data = {28'd0, status_q};
      5'd13:   bus.read_data = {26'd0, cause_src_q, 1'b0, pending_q};
      5'd14:   bus.read_data = epc_q;
      default: bus.read_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      status_q     <= ResetStatus;
      cause_src_q  <= '0;
      epc_q        <= '0;
      in_handler_q <= 1'b0;
    end else begin
      sync1_q      <= bus.irq_request;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      status_q     <= status_d;
      cause_src_q  <= cause_src_d;
      epc_q        <= epc_d;
      in_handler_q <= in_handler_d;
    end
  end

endmodule
